// File: rtl/vga_pkg.sv
// Shared VGA timing constants (1024x768 @ 60 Hz, 65 MHz pixel clock) and types.
// Optional frame counter in vga_timing_gen is enabled by VGA_TIMING_FRAME_CNT_EN.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  localparam int VGA_H_FP   = 24;
  localparam int VGA_H_SYNC = 136;
  localparam int VGA_H_BP   = 160;
  localparam int VGA_V_FP   = 3;
  localparam int VGA_V_SYNC = 6;
  localparam int VGA_V_BP   = 29;

  localparam int H_TOTAL = HOR_PIXELS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VER_PIXELS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W = 11;
  localparam int RGB_W = 12;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_flags_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing/pixel bus passed along the draw chain.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_wrap_cnt.sv
// Modulo-MOD counter with enable; exposes the next value so callers can
// register derived flags in the same cycle as the count.
module vga_wrap_cnt #(
  parameter int W   = 11,
  parameter int MOD = 1344
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt_nxt,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;

  assign wrap = (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_nxt = cnt_q;
    if (en) cnt_nxt = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Source of the vga_if bus: counters, active-high syncs, blanking and sof.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = HOR_PIXELS,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VER_PIXELS,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  vga_if.out          vga_out,
  output logic        sof
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] hcnt_nxt, hcnt, vcnt_nxt, vcnt;
  logic             hwrap, vwrap;
  vga_flags_t       flags_d, flags_q;
  logic             sof_d, sof_q;

  vga_wrap_cnt #(.W(CNT_W), .MOD(HT)) u_hcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pix_en),
    .cnt_nxt (hcnt_nxt),
    .cnt     (hcnt),
    .wrap    (hwrap)
  );

  vga_wrap_cnt #(.W(CNT_W), .MOD(VT)) u_vcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pix_en && hwrap),
    .cnt_nxt (vcnt_nxt),
    .cnt     (vcnt),
    .wrap    (vwrap)
  );

  // Flags follow the next counts, so they land in the same cycle as hcount/vcount.
  // With pix_en low the next counts equal the current ones and the flags hold.
  always_comb begin
    flags_d       = '0;
    flags_d.hblnk = in_range(hcnt_nxt, H_ACTIVE, HT);
    flags_d.hsync = in_range(hcnt_nxt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    flags_d.vblnk = in_range(vcnt_nxt, V_ACTIVE, VT);
    flags_d.vsync = in_range(vcnt_nxt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    sof_d         = pix_en && hwrap && vwrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      sof_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      sof_q   <= sof_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     fcnt_q <= '0;
    else if (sof_d) fcnt_q <= fcnt_q + 16'd1;
  end

  assign frame_cnt = fcnt_q;
`endif

  assign vga_out.hcount = hcnt;
  assign vga_out.vcount = vcnt;
  assign vga_out.hsync  = flags_q.hsync;
  assign vga_out.vsync  = flags_q.vsync;
  assign vga_out.hblnk  = flags_q.hblnk;
  assign vga_out.vblnk  = flags_q.vblnk;
  assign vga_out.rgb    = '0;
  assign sof            = sof_q;

endmodule
